fetch_unit: RTL and testbench

Instruction fetch and issue stage: the producer side of the decode interface that feeds opcodes to the control unit. It holds the program counter, fetches one instruction word at a time from instruction memory through a request/valid handshake, and presents the decoded fields with a valid/ready handshake. It also handles branch redirects, including discarding stale in-flight responses, and stops permanently on the HALT opcode.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: fetches one word at a time from instruction memory
// and presents decoded fields to the control unit, with branch redirect and HALT.
module fetch_unit #(
  parameter int          PC_WIDTH    = 8,
  parameter int          INSTR_WIDTH = 16,
  parameter logic [5:0]  HALT_OP     = 6'b111111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_valid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [5:0]             opcode,
  output logic [INSTR_WIDTH-7:0] operand,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   issue_ready,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   halted,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
  logic                   xfer;
  logic                   halt_hit;

  // Decode handshake: a word moves to the control unit on any rising edge where
  // instr_valid & issue_ready; while instr_valid is high and issue_ready is low,
  // opcode/operand/instr_pc hold and instr_valid does not drop except on redirect.
  assign xfer     = (state_q == S_ISSUE) && issue_ready;
  assign halt_hit = (instr_q[INSTR_WIDTH-1 -: 6] == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      S_REQ: begin
        instr_pc_d = pc_q;
        // The request leaves this cycle regardless, so a redirect must drain it.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = mem_valid ? S_REQ : S_DRAIN;
        end else if (mem_valid) begin
          instr_d = mem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (xfer && halt_hit) begin
          state_d = S_HALT;
        end else if (xfer || redirect_valid) begin
          if (redirect_valid) pc_d = redirect_pc;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (mem_valid) state_d = S_REQ;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = (state_q == S_REQ) ? pc_q : '0;
  assign instr_valid = (state_q == S_ISSUE);
  assign opcode      = instr_valid ? instr_q[INSTR_WIDTH-1 -: 6] : 6'b000000;
  assign operand     = instr_valid ? instr_q[INSTR_WIDTH-7:0] : '0;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state_q == S_HALT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model feeding a scoreboard of
// expected {pc, word} pairs, popped when the decode handshake transfers.
module tb_fetch_unit;

  localparam int PW = 8;
  localparam int IW = 16;

  logic          clk;
  logic          rst_n;
  logic          mem_req;
  logic [PW-1:0] mem_addr;
  logic          mem_valid;
  logic [IW-1:0] mem_rdata;
  logic [5:0]    opcode;
  logic [IW-7:0] operand;
  logic [PW-1:0] instr_pc;
  logic          instr_valid;
  logic          issue_ready;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          halted;
  logic [2:0]    dbg_state;

  logic [PW+IW-1:0] exp_q[$];
  logic [IW-1:0]    mem [256];
  int               lat;
  int               stray_req;
  int               cyc;
  int               n_vec;
  int               n_err;

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .HALT_OP(6'b111111)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .opcode(opcode), .operand(operand), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .issue_ready(issue_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .dbg_state_o(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 0);
    check({tag, "_opcode"}, {26'd0, opcode}, 0);
    check({tag, "_operand"}, {22'd0, operand}, 0);
    check({tag, "_instr_pc"}, {24'd0, instr_pc}, 0);
    check({tag, "_instr_valid"}, {31'd0, instr_valid}, 0);
    check({tag, "_halted"}, {31'd0, halted}, 0);
  endtask

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic apply_reset();
    @(posedge clk); #2; rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic drive_redirect(input logic [PW-1:0] target);
    @(posedge clk); #2; redirect_valid = 1'b1; redirect_pc = target;
    @(posedge clk); #2; redirect_valid = 1'b0;
  endtask

  task automatic wait_req(output logic [PW-1:0] a, output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 100);
    if (!mem_req) check("req_timeout", {31'd0, mem_req}, 1);
    a = mem_addr;
    c = cyc;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 100);
    if (!instr_valid) check("valid_timeout", {31'd0, instr_valid}, 1);
  endtask

  // Memory model and scoreboard, sampled on the falling edge.
  task automatic mem_and_monitor();
    logic          pend = 1'b0;
    logic          stale = 1'b0;
    int            cnt = 0;
    int            stray_seen = 0;
    logic [PW-1:0] raddr = '0;
    logic [PW+IW-1:0] e;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (!rst_n) begin
        pend = 1'b0;
        stale = 1'b0;
        exp_q.delete();
        continue;
      end
      if (instr_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("sb_opcode", {26'd0, opcode}, {26'd0, e[IW-1 -: 6]});
          check("sb_operand", {22'd0, operand}, {22'd0, e[IW-7:0]});
          check("sb_instr_pc", {24'd0, instr_pc}, {24'd0, e[PW+IW-1:IW]});
        end
      end else if (!instr_valid) begin
        check("nop_idle", {16'd0, opcode, operand}, 0);
      end
      if (redirect_valid && pend) stale = 1'b1;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem[raddr];
          pend = 1'b0;
          if (!stale) exp_q.push_back({raddr, mem[raddr]});
        end
      end else if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        mem_valid = 1'b1;
        mem_rdata = 16'hFC00;
      end
      if (mem_req) begin
        pend = 1'b1;
        cnt = lat;
        raddr = mem_addr;
        stale = redirect_valid;
      end
    end
  endtask

  initial begin
    logic [PW-1:0] a;
    logic [5:0]    op_hold;
    logic [IW-7:0] opr_hold;
    logic [PW-1:0] pc_hold;
    int c, prev, op, opr;

    rst_n = 1'b0; mem_valid = 1'b0; mem_rdata = '0; issue_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1; stray_req = 0;
    cyc = 0; n_vec = 0; n_err = 0;
    for (int i = 0; i < 256; i++) begin
      op  = $urandom_range(0, 62);
      opr = $urandom_range(0, 1023);
      mem[i] = {op[5:0], opr[9:0]};
    end
    mem[0]     = 16'h3805;
    mem[8'h80] = 16'hFC00;
    fork mem_and_monitor(); join_none

    // Reset values, then single-instruction latency with 1-cycle memory
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk); check("c0_req", {31'd0, mem_req}, 0);
    @(negedge clk); check("c1_req", {31'd0, mem_req}, 1);
    check("c1_addr", {24'd0, mem_addr}, 0);
    @(negedge clk); check("c2_req", {31'd0, mem_req}, 0);
    check("c2_valid", {31'd0, instr_valid}, 0);
    @(negedge clk); check("c3_valid", {31'd0, instr_valid}, 1);
    check("c3_opcode", {26'd0, opcode}, 32'h0E);
    check("c3_operand", {22'd0, operand}, 32'h005);
    check("c3_instr_pc", {24'd0, instr_pc}, 0);

    // Sequential fetch, memory latency 3: five cycles per instruction
    lat = 3;
    apply_reset();
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_req(a, c);
      check("seq_addr", {24'd0, a}, i);
      if (i > 0) check("seq_gap", c - prev, 5);
      prev = c;
    end

    // PC wrap
    lat = 1;
    drive_redirect(8'hFF);
    wait_req(a, c); check("wrap_addr0", {24'd0, a}, 32'hFF);
    wait_req(a, c); check("wrap_addr1", {24'd0, a}, 32'h00);

    // Backpressure in ISSUE
    @(posedge clk); #2; issue_ready = 1'b0;
    wait_valid();
    op_hold = opcode; opr_hold = operand; pc_hold = instr_pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, instr_valid}, 1);
      check("bp_stable", {opcode, operand, instr_pc}, {op_hold, opr_hold, pc_hold});
      check("bp_no_req", {31'd0, mem_req}, 0);
    end
    @(posedge clk); #2; issue_ready = 1'b1;
    @(negedge clk); check("bp_rel_valid", {31'd0, instr_valid}, 1);
    @(negedge clk); check("bp_rel_req", {31'd0, mem_req}, 1);

    // Redirect during WAIT with latency 2: stale word must never issue
    lat = 2;
    wait_req(a, c);
    drive_redirect(8'h40);
    wait_req(a, c); check("redir_addr", {24'd0, a}, 32'h40);
    wait_valid();   check("redir_instr_pc", {24'd0, instr_pc}, 32'h40);

    // HALT
    lat = 1;
    drive_redirect(8'h80);
    wait_valid();
    check("halt_pc", {24'd0, instr_pc}, 32'h80);
    check("halt_opcode", {26'd0, opcode}, 32'h3F);
    @(negedge clk);
    check("halt_flag", {31'd0, halted}, 1);
    check("halt_valid", {31'd0, instr_valid}, 0);
    drive_redirect(8'h10);
    stray_req++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_no_req", {31'd0, mem_req}, 0);
      check("halt_stay", {31'd0, halted}, 1);
    end
    check("sb_drained", exp_q.size(), 0);

    // Asynchronous reset out of HALT
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    check_zero("rst_async");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
